// File: rtl/processor_selftest.sv
// Self-test sequencer: holds a processor in reset, runs it for CYCLE_LIMIT cycles, then compares
// NUM_CHECKS register-file values against an external expectation table. Optional macro: SELFTEST_FAIL_LOG_EN.
module processor_selftest #(
    parameter int CYCLE_LIMIT = 9,
    parameter int NUM_CHECKS  = 8,
    parameter int ERR_W       = 8,
    localparam int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             dut_reset,
    output logic [IDX_W-1:0] exp_index,
    input  logic [4:0]       exp_reg,
    input  logic [31:0]      exp_value,
    output logic [4:0]       reg_rd_addr,
    input  logic [31:0]      reg_rd_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] error_count,
    output logic [15:0]      cycle_count,
    output logic             fail_valid,
    output logic [4:0]       fail_reg,
    output logic [31:0]      fail_expected,
    output logic [31:0]      fail_read
);

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_CHECK, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               hold_q, hold_d;
    logic [15:0]        cycle_q, cycle_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               start_run;
    logic               mismatch;
    logic               last_run;
    logic               last_idx;

    assign start_run = start && (state_q == S_IDLE || state_q == S_DONE);
    assign mismatch  = (state_q == S_CHECK) && (reg_rd_data != exp_value);
    assign last_run  = (cycle_q == 16'(CYCLE_LIMIT - 1));
    assign last_idx  = (idx_q == IDX_W'(NUM_CHECKS - 1));

    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)    state_d = S_HOLD;
            S_HOLD:  if (hold_q)   state_d = S_RUN;
            S_RUN:   if (last_run) state_d = S_CHECK;
            S_CHECK: if (last_idx) state_d = S_DONE;
            S_DONE:  if (start)    state_d = S_HOLD;
            default:               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dut_reset   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        pass        = 1'b0;
        reg_rd_addr = 5'd0;
        case (state_q)
            S_IDLE:  dut_reset = 1'b1;
            S_HOLD:  begin dut_reset = 1'b1; busy = 1'b1; end
            S_RUN:   busy = 1'b1;
            S_CHECK: begin busy = 1'b1; reg_rd_addr = exp_reg; end
            S_DONE:  begin done = 1'b1; pass = (err_q == '0); end
            default: dut_reset = 1'b1;
        endcase
    end

    // Counters only move in their own state; a new run clears them all at once.
    always_comb begin
        hold_d  = hold_q;
        cycle_d = cycle_q;
        idx_d   = idx_q;
        err_d   = err_q;
        if (start_run) begin
            hold_d  = 1'b0;
            cycle_d = '0;
            idx_d   = '0;
            err_d   = '0;
        end else begin
            case (state_q)
                S_HOLD:  hold_d  = ~hold_q;
                S_RUN:   cycle_d = cycle_q + 16'd1;
                S_CHECK: begin
                    idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
                    if (mismatch && err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_q  <= 1'b0;
            cycle_q <= '0;
            idx_q   <= '0;
            err_q   <= '0;
        end else begin
            hold_q  <= hold_d;
            cycle_q <= cycle_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign exp_index   = idx_q;
    assign error_count = err_q;
    assign cycle_count = cycle_q;

`ifdef SELFTEST_FAIL_LOG_EN
    logic        fvld_q, fvld_d;
    logic [4:0]  freg_q, freg_d;
    logic [31:0] fexp_q, fexp_d;
    logic [31:0] frd_q,  frd_d;

    // Only the first mismatch of a run is kept.
    always_comb begin
        fvld_d = fvld_q;
        freg_d = freg_q;
        fexp_d = fexp_q;
        frd_d  = frd_q;
        if (start_run) begin
            fvld_d = 1'b0;
            freg_d = '0;
            fexp_d = '0;
            frd_d  = '0;
        end else if (mismatch && !fvld_q) begin
            fvld_d = 1'b1;
            freg_d = exp_reg;
            fexp_d = exp_value;
            frd_d  = reg_rd_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fvld_q <= 1'b0;
            freg_q <= '0;
            fexp_q <= '0;
            frd_q  <= '0;
        end else begin
            fvld_q <= fvld_d;
            freg_q <= freg_d;
            fexp_q <= fexp_d;
            frd_q  <= frd_d;
        end
    end

    assign fail_valid    = fvld_q;
    assign fail_reg      = freg_q;
    assign fail_expected = fexp_q;
    assign fail_read     = frd_q;
`else
    assign fail_valid    = 1'b0;
    assign fail_reg      = 5'd0;
    assign fail_expected = 32'd0;
    assign fail_read     = 32'd0;
`endif

endmodule

// File: tb/tb_processor_selftest.sv
// Bench for processor_selftest: table-driven reference of expected error counts and first-mismatch record.
module tb_processor_selftest;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_a, start_b;

    logic        a_dut_reset, a_busy, a_done, a_pass, a_fv;
    logic [1:0]  a_idx;
    logic [4:0]  a_exp_reg, a_rd_addr, a_freg;
    logic [31:0] a_exp_val, a_rd_data, a_fexp, a_fread;
    logic [7:0]  a_err;
    logic [15:0] a_cc;

    logic        b_dut_reset, b_busy, b_done, b_pass, b_fv;
    logic [2:0]  b_idx;
    logic [4:0]  b_exp_reg, b_rd_addr, b_freg;
    logic [31:0] b_exp_val, b_rd_data, b_fexp, b_fread;
    logic [1:0]  b_err;
    logic [15:0] b_cc;

    logic [31:0] rf [32];
    logic [4:0]  ta_reg [4];
    logic [31:0] ta_val [4];
    logic [4:0]  tb_reg [8];
    logic [31:0] tb_val [8];

    assign a_exp_reg = ta_reg[a_idx];
    assign a_exp_val = ta_val[a_idx];
    assign a_rd_data = rf[a_rd_addr];
    assign b_exp_reg = tb_reg[b_idx];
    assign b_exp_val = tb_val[b_idx];
    assign b_rd_data = rf[b_rd_addr];

    processor_selftest #(.CYCLE_LIMIT(9), .NUM_CHECKS(4), .ERR_W(8)) u_a (
        .clock(clk), .reset(rst_n), .start(start_a), .dut_reset(a_dut_reset),
        .exp_index(a_idx), .exp_reg(a_exp_reg), .exp_value(a_exp_val),
        .reg_rd_addr(a_rd_addr), .reg_rd_data(a_rd_data),
        .busy(a_busy), .done(a_done), .pass(a_pass), .error_count(a_err), .cycle_count(a_cc),
        .fail_valid(a_fv), .fail_reg(a_freg), .fail_expected(a_fexp), .fail_read(a_fread)
    );

    processor_selftest #(.CYCLE_LIMIT(3), .NUM_CHECKS(8), .ERR_W(2)) u_b (
        .clock(clk), .reset(rst_n), .start(start_b), .dut_reset(b_dut_reset),
        .exp_index(b_idx), .exp_reg(b_exp_reg), .exp_value(b_exp_val),
        .reg_rd_addr(b_rd_addr), .reg_rd_data(b_rd_data),
        .busy(b_busy), .done(b_done), .pass(b_pass), .error_count(b_err), .cycle_count(b_cc),
        .fail_valid(b_fv), .fail_reg(b_freg), .fail_expected(b_fexp), .fail_read(b_fread)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outcome of a run: every table entry whose register value differs is one error.
    task automatic model_a(output int err, output logic fv, output logic [4:0] fr,
                           output logic [31:0] fe, output logic [31:0] fd);
        err = 0; fv = 1'b0; fr = '0; fe = '0; fd = '0;
        for (int i = 0; i < 4; i++) begin
            if (rf[ta_reg[i]] != ta_val[i]) begin
                if (!fv) begin
                    fv = 1'b1; fr = ta_reg[i]; fe = ta_val[i]; fd = rf[ta_reg[i]];
                end
                err++;
            end
        end
        if (err > 255) err = 255;
`ifndef SELFTEST_FAIL_LOG_EN
        fv = 1'b0; fr = '0; fe = '0; fd = '0;
`endif
    endtask

    task automatic run_a(input bit pulse_mid);
        int n, e_err, e_cc;
        logic e_fv;
        logic [4:0] e_fr;
        logic [31:0] e_fe, e_fd;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        chk("busy_after_start", a_busy, 1);
        chk("done_after_start", a_done, 0);
        chk("err_cleared", a_err, 0);
        chk("cc_cleared", a_cc, 0);
        chk("fv_cleared", a_fv, 0);
        while (!a_done && n < 200) begin
            start_a = (pulse_mid && n == 5);
            tick();
            n++;
            if (!a_done) begin
                e_cc = (n < 2) ? 0 : ((n - 2 > 9) ? 9 : n - 2);
                chk("dut_reset_phase", a_dut_reset, (n < 2));
                chk("cc_phase", a_cc, e_cc);
            end
        end
        start_a = 1'b0;
        chk("done_latency", n, 15);
        model_a(e_err, e_fv, e_fr, e_fe, e_fd);
        chk("err_count", a_err, e_err);
        chk("pass", a_pass, (e_err == 0));
        chk("fail_valid", a_fv, e_fv);
        chk("fail_reg", a_freg, e_fr);
        chk("fail_expected", a_fexp, e_fe);
        chk("fail_read", a_fread, e_fd);
        chk("cc_final", a_cc, 9);
        chk("busy_done", a_busy, 0);
        chk("dut_reset_done", a_dut_reset, 0);
        tick();
        tick();
        chk("done_hold", a_done, 1);
        chk("err_hold", a_err, e_err);
        chk("fail_reg_hold", a_freg, e_fr);
    endtask

    initial begin
        int n, cnt;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int i = 0; i < 4; i++) begin ta_reg[i] = '0; ta_val[i] = '0; end
        for (int i = 0; i < 8; i++) begin tb_reg[i] = '0; tb_val[i] = '0; end
        tick(); tick(); tick();

        chk("rst_dut_reset", a_dut_reset, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_pass", a_pass, 0);
        chk("rst_err", a_err, 0);
        chk("rst_cc", a_cc, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_rd_addr", a_rd_addr, 0);
        chk("rst_fv", a_fv, 0);
        chk("rst_freg", a_freg, 0);
        chk("rst_fexp", a_fexp, 0);
        chk("rst_fread", a_fread, 0);
        chk("rst_b_dut_reset", b_dut_reset, 1);
        rst_n = 1'b1;
        tick();
        chk("idle_no_start", a_busy, 0);

        // All expectations match.
        for (int i = 0; i < 4; i++) begin
            ta_reg[i] = 5'($urandom_range(0, 31));
            ta_val[i] = rf[ta_reg[i]];
        end
        run_a(0);
        chk("all_match_err", a_err, 0);

        // Index 1 (r2: expect 5, read 7) and index 3 mismatch.
        rf[2] = 32'd7;
        ta_reg[0] = 5'd1; ta_val[0] = rf[1];
        ta_reg[1] = 5'd2; ta_val[1] = 32'd5;
        ta_reg[2] = 5'd3; ta_val[2] = rf[3];
        ta_reg[3] = 5'd4; ta_val[3] = rf[4] ^ 32'h1;
        run_a(0);
        chk("two_mismatch_err", a_err, 2);

        // Random mixture, restarted from DONE, with start pulsed during RUN.
        for (int i = 0; i < 4; i++) begin
            ta_reg[i] = 5'($urandom_range(0, 31));
            ta_val[i] = $urandom_range(0, 1) ? rf[ta_reg[i]] : $urandom;
        end
        run_a(1);

        // Saturation: eight mismatches into a 2-bit counter.
        for (int i = 0; i < 8; i++) begin
            tb_reg[i] = 5'($urandom_range(0, 31));
            tb_val[i] = ~rf[tb_reg[i]];
        end
        cnt = 0;
        for (int i = 0; i < 8; i++) if (rf[tb_reg[i]] != tb_val[i]) cnt++;
        if (cnt > 3) cnt = 3;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!b_done && n < 200) begin tick(); n++; end
        chk("b_done_latency", n, 13);
        chk("b_err_sat", b_err, cnt);
        chk("b_pass", b_pass, 0);
        chk("b_cc", b_cc, 3);

        // Reset in the middle of RUN.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("midrun_cc", a_cc, 3);
        chk("midrun_busy", a_busy, 1);
        chk("midrun_dut_reset", a_dut_reset, 0);
        rst_n = 1'b0;
        tick();
        chk("rst_run_dut_reset", a_dut_reset, 1);
        chk("rst_run_cc", a_cc, 0);
        chk("rst_run_busy", a_busy, 0);
        chk("rst_run_done", a_done, 0);
        chk("rst_run_err", a_err, 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("after_rst_idle", a_busy, 0);
        chk("after_rst_dut_reset", a_dut_reset, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/processor_selftest.md
PROCESSOR_SELFTEST -- requirements
Module: processor_selftest

Interface
REQ-001 SHALL have parameter CYCLE_LIMIT, default 9: number of processor clock cycles run before checking (1..65535).
REQ-002 SHALL have parameter NUM_CHECKS, default 8: number of register expectations checked (1..32).
REQ-003 SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-004 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port start  in  1  single-cycle request to begin a test run.
REQ-007 SHALL have port dut_reset  out  1  active-high reset driven to the processor under test.
REQ-008 SHALL have port exp_index  out  $clog2(NUM_CHECKS) (min 1)  index into the external expectation table.
REQ-009 SHALL have port exp_reg  in  5  register number for the current index, combinational from exp_index.
REQ-010 SHALL have port exp_value  in  32  expected value for the current index, combinational from exp_index.
REQ-011 SHALL have port reg_rd_addr  out  5  register-file debug read address.
REQ-012 SHALL have port reg_rd_data  in  32  register-file debug read data, combinational from reg_rd_addr.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE and DONE.
REQ-014 SHALL have port done  out  1  high while in DONE.
REQ-015 SHALL have port pass  out  1  high in DONE when error_count is zero.
REQ-016 SHALL have port error_count  out  ERR_W  mismatches counted in the current run.
REQ-017 SHALL have port cycle_count  out  16  RUN cycles elapsed in the current run.
REQ-018 SHALL have ports fail_valid (1), fail_reg (5), fail_expected (32), fail_read (32), all outputs carrying the first-mismatch record.

Function
REQ-019 SHALL implement FSM IDLE -> HOLD -> RUN -> CHECK -> DONE.
REQ-020 IDLE: dut_reset=1; start=1 SHALL move to HOLD and clear error_count, cycle_count, index and the fail record.
REQ-021 HOLD SHALL last exactly 2 cycles with dut_reset=1, then move to RUN.
REQ-022 RUN: dut_reset=0; cycle_count SHALL increment each cycle; after exactly CYCLE_LIMIT RUN cycles, move to CHECK.
REQ-023 CHECK: dut_reset SHALL stay 0 and the processor keeps clocking; index i drives exp_index=i and reg_rd_addr=exp_reg.
REQ-024 At each CHECK edge, reg_rd_data!==exp_value SHALL increment error_count; index i advances by 1; after index NUM_CHECKS-1 the FSM moves to DONE.
REQ-025 error_count SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-026 done SHALL rise exactly 2+CYCLE_LIMIT+NUM_CHECKS cycles after the edge that samples start in IDLE.
REQ-027 start SHALL be ignored in HOLD, RUN and CHECK.
REQ-028 start=1 in DONE SHALL restart at HOLD with counters cleared.
REQ-029 DONE SHALL hold error_count, pass and the fail record stable, with dut_reset=0.
REQ-030 A comparison in any state other than CHECK SHALL NOT affect error_count.

Reset
REQ-031 reset=0 at a rising edge SHALL force IDLE in any state, including mid-RUN and mid-CHECK.
REQ-032 Reset values SHALL be: dut_reset=1; busy, done, pass and fail_valid 0; error_count, cycle_count, exp_index, reg_rd_addr, fail_reg, fail_expected and fail_read 0.

Configuration
REQ-033 With macro SELFTEST_FAIL_LOG_EN defined, the first mismatch of a run SHALL capture exp_reg, exp_value and reg_rd_data into fail_reg, fail_expected and fail_read, and set fail_valid=1; later mismatches SHALL NOT overwrite the record.
REQ-034 Without SELFTEST_FAIL_LOG_EN, fail_valid, fail_reg, fail_expected and fail_read SHALL be constant 0 and no capture registers SHALL exist.

Verification
REQ-035 Bench SHALL cover: CYCLE_LIMIT=9, NUM_CHECKS=4, all 4 expectations match -> done rises 15 cycles after start, pass=1, error_count=0.
REQ-036 Bench SHALL cover: expectations at index 1 (r2 exp 5, read 7) and index 3 mismatch -> error_count=2, pass=0; with SELFTEST_FAIL_LOG_EN, fail_reg=2, fail_expected=5, fail_read=7.
REQ-037 Bench SHALL cover: ERR_W=2, NUM_CHECKS=8, all mismatching -> error_count saturates at 3.
REQ-038 Bench SHALL cover: reset=0 at RUN cycle 4 -> next cycle IDLE, dut_reset=1, cycle_count=0, busy=0.
REQ-039 Bench SHALL cover: start pulsed during RUN -> no effect, done timing unchanged; start in DONE -> HOLD, error_count=0.
REQ-040 Bench SHALL cover: build without SELFTEST_FAIL_LOG_EN and a mismatching run -> fail_* outputs remain 0, error_count correct.
